umich_op_arbiter: RTL and testbench
===================================

UMICH_OP_ARBITER -- requirements
Module: umich_op_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the operator unit (2..8).
REQ-002 Parameter W, default 64: operand/result width.
REQ-003 Parameter MULT_LAT, default 3: EXEC cycles for MULT (>=1).
REQ-004 Reset synch_preset, asynchronous, active-high; clock clocked_on.
REQ-005 clocked_on  input  1  rising-edge clock.
REQ-006 synch_preset  input  1  async active-high reset.
REQ-007 req_valid  input  NREQ  per-requester request valid.
REQ-008 req_ready  output  NREQ  per-requester accept, at most one bit set.
REQ-009 req_op  input  3*NREQ  opcode per requester, slot i at [3i+2:3i].
REQ-010 req_a  input  W*NREQ  operand A per requester.
REQ-011 req_b  input  W*NREQ  operand B per requester.
REQ-012 rsp_valid  output  1  result valid.
REQ-013 rsp_ready  input  1  result consumer ready.
REQ-014 rsp_id  output  clog2(NREQ)  index of the requester owning the result.
REQ-015 rsp_data  output  W  result.
REQ-016 rsp_err  output  1  illegal-opcode or disabled-op flag.
REQ-017 busy  output  1  high whenever state != IDLE.

Function
REQ-018 FSM states IDLE, EXEC, RESP; one operation in flight at most.
REQ-019 IDLE: if any req_valid, grant lowest index >= ptr (wrapping mod NREQ) with req_valid set; req_ready[grant] high combinationally in IDLE only.
REQ-020 On req_valid&req_ready: latch op, A, B, id; go EXEC; ptr <= (grant+1) mod NREQ.
REQ-021 EXEC lasts 1 cycle for ADD(0), SUB(1), LT_UNS(3), LT_TC(4), EQ(5), ASH(6), illegal(7); MULT_LAT cycles for MULT(2); then RESP.
REQ-022 Arithmetic modulo 2^W; MULT keeps low W bits; LT_TC signed compare; compare results zero-extended 1-bit; ASH = A << B, result 0 when B >= W.
REQ-023 Opcode 7: rsp_data=0, rsp_err=1.
REQ-024 RESP: rsp_valid=1, rsp_id/rsp_data/rsp_err held stable until rsp_ready; on handshake go IDLE.
REQ-025 rsp_ready high in the first RESP cycle completes the transfer that cycle; minimum request-to-request spacing is 3 cycles (IDLE, EXEC, RESP).
REQ-026 Requests arriving while busy are not accepted; requesters hold req_valid, and dropped req_valid loses no state.
REQ-027 rsp_valid, rsp_data, rsp_err, rsp_id are 0 outside RESP.

Reset
REQ-028 synch_preset asserted: state=IDLE, ptr=0, EXEC counter=0, all outputs 0, any in-flight operation discarded, including mid-EXEC or mid-RESP.
REQ-029 First grant after reset deassertion occurs no earlier than the first clocked_on edge with synch_preset low.

Configuration
REQ-030 Macro UMICH_OP_ARB_MULT_EN defined: MULT per REQ-021/022.
REQ-031 Macro undefined: no multiplier instantiated; MULT treated as opcode 7 (1-cycle EXEC, rsp_data=0, rsp_err=1).

Structure
REQ-032 Package umich_op_pkg holds the opcode enum, the FSM state enum, and the constant OP_W=3.
REQ-033 Sub-module umich_op_exec: registered operand inputs, opcode-selected result, and done pulse after the per-op latency; arbiter FSM and pointer stay in umich_op_arbiter.

Verification
REQ-034 Reset, req_valid=4'b0001, op ADD, A=5, B=7 -> req_ready[0] same cycle; rsp_valid two cycles later with rsp_id=0, rsp_data=12, rsp_err=0.
REQ-035 All four req_valid held high, rsp_ready=1 -> grants ordered 0,1,2,3,0, one every 3 cycles.
REQ-036 MULT A=3, B=0xFFFFFFFFFFFFFFFF with UMICH_OP_ARB_MULT_EN -> rsp_data=0xFFFFFFFFFFFFFFFD after MULT_LAT EXEC cycles; without macro -> rsp_err=1, rsp_data=0 after 1 cycle.
REQ-037 LT_TC A=-1, B=0 -> rsp_data=1; LT_UNS same operands -> 0; ASH A=1, B=64 -> 0; opcode 7 -> rsp_err=1.
REQ-038 rsp_ready low for 5 cycles in RESP -> rsp_valid, rsp_data, rsp_id stable; req_ready stays 0 until handshake.
REQ-039 synch_preset pulsed mid-EXEC of a MULT -> busy=0 immediately, no rsp_valid, next grant goes to requester 0.

Source files
------------

// File: rtl/umich_op_arbiter_pkg.sv
// Shared opcode/state types for the operator-unit arbiter slice.
// Optional multiplier is enabled by defining UMICH_OP_ARB_MULT_EN.
package umich_op_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 3'd0,
    OP_SUB    = 3'd1,
    OP_MULT   = 3'd2,
    OP_LT_UNS = 3'd3,
    OP_LT_TC  = 3'd4,
    OP_EQ     = 3'd5,
    OP_ASH    = 3'd6,
    OP_ILL    = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/umich_op_arbiter_if.sv
// Request/response bundle between requesters and the shared operator arbiter.
interface umich_op_arbiter_if
  import umich_op_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 64
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [OP_W*NREQ-1:0] req_op;
  logic [W*NREQ-1:0]    req_a;
  logic [W*NREQ-1:0]    req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [W-1:0]         rsp_data;
  logic                 rsp_err;
  logic                 busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

endinterface

// File: rtl/umich_op_arbiter_exec.sv
// Operator datapath: latches operands on start, raises done after the per-op latency.
// MULT is real only when UMICH_OP_ARB_MULT_EN is defined; otherwise it reports an error.
module umich_op_exec
  import umich_op_pkg::*;
#(
  parameter int W        = 64,
  parameter int MULT_LAT = 3
) (
  input  logic            clocked_on,
  input  logic            synch_preset,
  input  logic            start,
  input  logic [OP_W-1:0] op,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic            done,
  output logic [W-1:0]    result,
  output logic            err
);
`ifdef UMICH_OP_ARB_MULT_EN
  localparam int MULT_CYC = MULT_LAT;
`else
  localparam int MULT_CYC = 1;
`endif
  localparam int CNT_W = (MULT_CYC > 1) ? $clog2(MULT_CYC) : 1;

  op_e                 op_p0;
  logic [W-1:0]        a_p0, b_p0;
  logic signed [W-1:0] sa_p0, sb_p0;
  logic                vld_p0;
  logic [CNT_W-1:0]    cnt_p0;

  always_ff @(posedge clocked_on or posedge synch_preset) begin
    if (synch_preset) begin
      vld_p0 <= 1'b0;
      cnt_p0 <= '0;
    end else if (start) begin
      vld_p0 <= 1'b1;
      cnt_p0 <= (op_e'(op) == OP_MULT) ? CNT_W'(MULT_CYC - 1) : '0;
    end else if (vld_p0) begin
      if (cnt_p0 == '0) vld_p0 <= 1'b0;
      else              cnt_p0 <= cnt_p0 - 1'b1;
    end
  end

  // ---- p0: operands held until the next accepted request
  always_ff @(posedge clocked_on) begin
    if (start) begin
      op_p0 <= op_e'(op);
      a_p0  <= a;
      b_p0  <= b;
    end
  end

  assign sa_p0 = a_p0;
  assign sb_p0 = b_p0;
  assign done  = vld_p0 && (cnt_p0 == '0);

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (op_p0)
      OP_ADD:    result = a_p0 + b_p0;
      OP_SUB:    result = a_p0 - b_p0;
`ifdef UMICH_OP_ARB_MULT_EN
      OP_MULT:   result = a_p0 * b_p0;
`else
      OP_MULT:   err = 1'b1;
`endif
      OP_LT_UNS: result = W'(a_p0 < b_p0);
      OP_LT_TC:  result = W'(sa_p0 < sb_p0);
      OP_EQ:     result = W'(a_p0 == b_p0);
      // shift amounts >= W already yield zero under SV shift semantics
      OP_ASH:    result = a_p0 << b_p0;
      default:   err = 1'b1;
    endcase
  end

endmodule

// File: rtl/umich_op_arbiter.sv
// Round-robin arbiter sharing one operator unit among NREQ requesters (IDLE/EXEC/RESP).
// Define UMICH_OP_ARB_MULT_EN to enable the multi-cycle multiplier.
module umich_op_arbiter
  import umich_op_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int W        = 64,
  parameter int MULT_LAT = 3
) (
  input  logic              clocked_on,
  input  logic              synch_preset,
  umich_op_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  state_e          state, state_nxt;
  logic [IDW-1:0]  ptr, ptr_nxt, grant, id_p0;
  logic            any_vld, start, done, err;
  logic [OP_W-1:0] op_sel;
  logic [W-1:0]    a_sel, b_sel, result;

  // Scan downward so the last hit is the lowest offset from ptr.
  always_comb begin
    int idx;
    any_vld = 1'b0;
    grant   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (bus.req_valid[idx]) begin
        any_vld = 1'b1;
        grant   = IDW'(idx);
      end
    end
    ptr_nxt = IDW'((int'(grant) + 1) % NREQ);
    op_sel  = bus.req_op[OP_W*int'(grant) +: OP_W];
    a_sel   = bus.req_a[W*int'(grant) +: W];
    b_sel   = bus.req_b[W*int'(grant) +: W];
  end

  always_ff @(posedge clocked_on or posedge synch_preset) begin
    if (synch_preset) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (start) ptr <= ptr_nxt;
    end
  end

  always_ff @(posedge clocked_on) begin
    if (start) id_p0 <= grant;
  end

  always_comb begin
    state_nxt     = state;
    start         = 1'b0;
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    bus.rsp_id    = '0;
    bus.rsp_data  = '0;
    bus.rsp_err   = 1'b0;
    bus.busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (any_vld && !synch_preset) begin
          bus.req_ready = NREQ'(1'b1) << grant;
          start         = 1'b1;
          state_nxt     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (done) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_id    = id_p0;
        bus.rsp_data  = result;
        bus.rsp_err   = err;
        if (bus.rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  umich_op_exec #(
    .W        (W),
    .MULT_LAT (MULT_LAT)
  ) u_exec (
    .clocked_on   (clocked_on),
    .synch_preset (synch_preset),
    .start        (start),
    .op           (op_sel),
    .a            (a_sel),
    .b            (b_sel),
    .done         (done),
    .result       (result),
    .err          (err)
  );

endmodule

// File: tb/tb_umich_op_arbiter.sv
// Randomized transaction-level bench for umich_op_arbiter against a rule-based reference model.
module tb_umich_op_arbiter;
  localparam int NREQ     = 4;
  localparam int W        = 64;
  localparam int MULT_LAT = 3;
`ifdef UMICH_OP_ARB_MULT_EN
  localparam bit MULT_EN = 1'b1;
`else
  localparam bit MULT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  umich_op_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  umich_op_arbiter #(.NREQ(NREQ), .W(W), .MULT_LAT(MULT_LAT)) dut (
    .clocked_on   (clk),
    .synch_preset (rst),
    .bus          (bus)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  int          mdl_ptr = 0;
  logic [2:0]  op_s [NREQ];
  logic [63:0] a_s  [NREQ];
  logic [63:0] b_s  [NREQ];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_slots(input logic [NREQ-1:0] vmask);
    for (int i = 0; i < NREQ; i++) begin
      bus.req_op[3*i +: 3] = op_s[i];
      bus.req_a[64*i +: 64] = a_s[i];
      bus.req_b[64*i +: 64] = b_s[i];
    end
    bus.req_valid = vmask;
  endtask

  function automatic int exp_grant(input logic [NREQ-1:0] vmask);
    int g = -1;
    for (int k = 0; k < NREQ; k++)
      if (g < 0 && vmask[(mdl_ptr + k) % NREQ]) g = (mdl_ptr + k) % NREQ;
    return g;
  endfunction

  function automatic void ref_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] r, output logic e, output int lat);
    r = 64'd0; e = 1'b0; lat = 1;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: if (MULT_EN) begin r = a * b; lat = MULT_LAT; end else e = 1'b1;
      3'd3: r = (a < b) ? 64'd1 : 64'd0;
      3'd4: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      3'd5: r = (a == b) ? 64'd1 : 64'd0;
      3'd6: r = (b >= 64) ? 64'd0 : (a << b[5:0]);
      default: e = 1'b1;
    endcase
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 3))
      0:       return 64'd0;
      1:       return '1;
      2:       return {$urandom, $urandom};
      default: return 64'($urandom_range(0, 70));
    endcase
  endfunction

  // One full request/response transaction; hold = cycles rsp_ready stays low in RESP.
  task automatic txn(input logic [NREQ-1:0] vmask, input int hold);
    logic [63:0] er;
    logic        ee;
    int          lat, g, n, t0;
    drive_slots(vmask);
    bus.rsp_ready = (hold == 0);
    #1;
    t0 = cyc;
    g  = exp_grant(vmask);
    ref_op(op_s[g], a_s[g], b_s[g], er, ee, lat);
    chk("req_ready_grant", 64'(bus.req_ready), 64'd1 << g);
    chk("busy_idle", 64'(bus.busy), 64'd0);
    chk("rsp_valid_idle", 64'(bus.rsp_valid), 64'd0);
    step();
    mdl_ptr = (g + 1) % NREQ;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      chk("req_ready_exec", 64'(bus.req_ready), 64'd0);
      chk("busy_exec", 64'(bus.busy), 64'd1);
      step();
      n++;
    end
    chk("exec_latency", 64'(n), 64'(lat));
    chk("rsp_id", 64'(bus.rsp_id), 64'(g));
    chk("rsp_data", bus.rsp_data, er);
    chk("rsp_err", 64'(bus.rsp_err), 64'(ee));
    for (int h = 1; h < hold; h++) begin
      step();
      chk("rsp_valid_hold", 64'(bus.rsp_valid), 64'd1);
      chk("rsp_data_hold", bus.rsp_data, er);
      chk("rsp_id_hold", 64'(bus.rsp_id), 64'(g));
      chk("req_ready_hold", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    step();
    chk("rsp_valid_after", 64'(bus.rsp_valid), 64'd0);
    chk("rsp_data_after", bus.rsp_data, 64'd0);
    chk("spacing", 64'(cyc - t0), 64'(lat + 2 + ((hold > 0) ? hold - 1 : 0)));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin op_s[i] = 3'd0; a_s[i] = 64'd1; b_s[i] = 64'd2; end
    drive_slots(4'b1111);
    step();
    step();
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_data", bus.rsp_data, 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    bus.req_valid = '0;
    rst = 1'b0;
    mdl_ptr = 0;
    step();

    op_s[0] = 3'd0; a_s[0] = 64'd5; b_s[0] = 64'd7;
    txn(4'b0001, 0);

    for (int i = 0; i < NREQ; i++) begin op_s[i] = 3'd0; a_s[i] = 64'(i * 10); b_s[i] = 64'd3; end
    for (int t = 0; t < 5; t++) txn(4'b1111, 0);

    op_s[2] = 3'd2; a_s[2] = 64'd3; b_s[2] = '1;
    txn(4'b0100, 0);

    op_s[1] = 3'd4; a_s[1] = '1; b_s[1] = 64'd0;
    txn(4'b0010, 0);
    op_s[1] = 3'd3;
    txn(4'b0010, 1);
    op_s[1] = 3'd6; a_s[1] = 64'd1; b_s[1] = 64'd64;
    txn(4'b0010, 0);
    op_s[1] = 3'd7; a_s[1] = 64'd9; b_s[1] = 64'd9;
    txn(4'b0010, 0);

    op_s[3] = 3'd1; a_s[3] = 64'd2; b_s[3] = 64'd5;
    txn(4'b1000, 5);

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        op_s[i] = 3'($urandom_range(0, 7));
        a_s[i]  = pick();
        b_s[i]  = pick();
      end
      txn(4'($urandom_range(1, 15)), $urandom_range(0, 3));
    end

    // Reset in the middle of a MULT must drop it and restart the pointer.
    op_s[2] = 3'd2; a_s[2] = 64'd3; b_s[2] = 64'd4;
    drive_slots(4'b0100);
    bus.rsp_ready = 1'b1;
    #1;
    step();
    chk("mid_exec_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("preset_busy", 64'(bus.busy), 64'd0);
    chk("preset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("preset_req_ready", 64'(bus.req_ready), 64'd0);
    step();
    chk("preset_rsp_valid2", 64'(bus.rsp_valid), 64'd0);
    rst = 1'b0;
    mdl_ptr = 0;
    for (int i = 0; i < NREQ; i++) begin op_s[i] = 3'd5; a_s[i] = 64'(i); b_s[i] = 64'd2; end
    txn(4'b1111, 0);
    chk("post_preset_ptr_model", 64'(mdl_ptr), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
